dma_desc_fifo: RTL and testbench

Parametrised multi-word descriptor FIFO for the DMA datapath. Descriptor words arrive one per cycle on a valid/ready write port and are packed into entries of WORDS_PER_ENTRY words. Each complete entry is presented in parallel on a valid/ready read port. It gives the DMA channel engine back-pressure, an occupancy count, an almost-full flag and a synchronous flush.

---
 rtl/dma_fifo_pkg.sv | 17 +
 rtl/dma_desc_assembler.sv | 66 ++++++
 rtl/dma_desc_fifo.sv | 117 +++++++++++
 tb/tb_dma_desc_fifo.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_fifo_pkg.sv
// Shared constants, the default descriptor entry type and a width helper
// for the DMA descriptor FIFO.
package dma_fifo_pkg;

    localparam int DMA_FIFO_WORD_W = 32;
    localparam int DMA_FIFO_WPE    = 3;
    localparam int DMA_FIFO_DEPTH  = 16;

    // One packed descriptor entry: word k lives in element [k].
    typedef logic [DMA_FIFO_WPE-1:0][DMA_FIFO_WORD_W-1:0] dma_desc_t;

    // Width needed to count 0..depth inclusive.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dma_desc_assembler.sv
// Packs word-serial descriptor words into one entry. Holds the partial
// entry and the slot index; raises commit_o on the accept that supplies the
// last word, with that word forwarded straight from word_i into entry_o.
module dma_desc_assembler
    import dma_fifo_pkg::*;
#(
    parameter int WORD_W          = DMA_FIFO_WORD_W,
    parameter int WORDS_PER_ENTRY = DMA_FIFO_WPE,
    parameter int IDX_W           = $clog2(WORDS_PER_ENTRY) + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush_i,
    input  logic                              accept_i,
    input  logic [WORD_W-1:0]                 word_i,
    output logic [IDX_W-1:0]                  idx_o,
    output logic                              commit_o,
    output logic [WORDS_PER_ENTRY*WORD_W-1:0] entry_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_ENTRY - 1);

    logic [IDX_W-1:0] idx_q;

    // Slot index: advances per accepted word, wraps after the last slot,
    // and is cleared by flush so a partial entry is simply forgotten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else if (flush_i) begin
            idx_q <= '0;
        end else if (accept_i) begin
            idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    assign idx_o    = idx_q;
    assign commit_o = accept_i && (idx_q == LAST_IDX);

    if (WORDS_PER_ENTRY > 1) begin : g_multi
        logic [WORD_W-1:0] asm_q [WORDS_PER_ENTRY-1];

        // Capture every word except the last one into its slot register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < WORDS_PER_ENTRY - 1; k++) asm_q[k] <= '0;
            end else if (accept_i) begin
                for (int k = 0; k < WORDS_PER_ENTRY - 1; k++) begin
                    if (idx_q == IDX_W'(k)) asm_q[k] <= word_i;
                end
            end
        end

        // Full entry view: stored words plus the incoming last word.
        always_comb begin
            entry_o = '0;
            for (int k = 0; k < WORDS_PER_ENTRY - 1; k++) begin
                entry_o[k*WORD_W +: WORD_W] = asm_q[k];
            end
            entry_o[(WORDS_PER_ENTRY-1)*WORD_W +: WORD_W] = word_i;
        end
    end else begin : g_single
        assign entry_o = word_i;
    end

endmodule

// File: rtl/dma_desc_fifo.sv
// Multi-word descriptor FIFO for the DMA datapath. Words are assembled into
// entries by dma_desc_assembler; this level owns the entry memory, the
// read/write pointers, the occupancy count, status flags and overflow error.
module dma_desc_fifo
    import dma_fifo_pkg::*;
#(
    parameter int WORD_W          = DMA_FIFO_WORD_W,
    parameter int WORDS_PER_ENTRY = DMA_FIFO_WPE,
    parameter int DEPTH           = DMA_FIFO_DEPTH,
    parameter int AFULL_THRESH    = 14
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush_i,
    input  logic                                   wr_valid_i,
    output logic                                   wr_ready_o,
    input  logic [WORD_W-1:0]                      wr_data_i,
    output logic [$clog2(WORDS_PER_ENTRY):0]       wr_idx_o,
    output logic                                   rd_valid_o,
    input  logic                                   rd_ready_i,
    output logic [WORDS_PER_ENTRY*WORD_W-1:0]      rd_data_o,
    output logic [fifo_cnt_w(DEPTH)-1:0]           count_o,
    output logic                                   full_o,
    output logic                                   empty_o,
    output logic                                   afull_o,
    output logic                                   ovf_err_o
);

    localparam int ENTRY_W = WORDS_PER_ENTRY * WORD_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = fifo_cnt_w(DEPTH);
    localparam int IDX_W   = $clog2(WORDS_PER_ENTRY) + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               ovf_q;

    logic               accept;
    logic               pop;
    logic               commit;
    logic [ENTRY_W-1:0] entry;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign afull_o    = (count_q >= CNT_W'(AFULL_THRESH));
    assign count_o    = count_q;
    assign ovf_err_o  = ovf_q;

    // Flush blocks the write port for that cycle so no word sneaks in.
    assign wr_ready_o = !full_o && !flush_i;
    assign rd_valid_o = !empty_o;
    assign rd_data_o  = empty_o ? '0 : mem[rd_ptr_q];

    assign accept = wr_valid_i && wr_ready_o;
    assign pop    = rd_valid_o && rd_ready_i && !flush_i;

    dma_desc_assembler #(
        .WORD_W          (WORD_W),
        .WORDS_PER_ENTRY (WORDS_PER_ENTRY),
        .IDX_W           (IDX_W)
    ) u_asm (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (flush_i),
        .accept_i (accept),
        .word_i   (wr_data_i),
        .idx_o    (wr_idx_o),
        .commit_o (commit),
        .entry_o  (entry)
    );

    // Entry storage is intentionally not reset; it is only read when valid.
    always_ff @(posedge clk) begin
        if (commit) mem[wr_ptr_q] <= entry;
    end

    // Pointers wrap naturally; fullness is judged from the count instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (commit) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Occupancy: a simultaneous commit and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (flush_i) begin
            count_q <= '0;
        end else if (commit && !pop) begin
            count_q <= count_q + CNT_W'(1);
        end else if (!commit && pop) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    // Sticky overflow: a word offered while the FIFO could not take it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (flush_i) begin
            ovf_q <= 1'b0;
        end else if (wr_valid_i && !wr_ready_o) begin
            ovf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dma_desc_fifo.sv
// Self-checking bench for dma_desc_fifo: directed scenarios plus a random
// run, all compared against a queue-based reference model.
module tb_dma_desc_fifo;
    import dma_fifo_pkg::*;

    localparam int WORD_W  = 32;
    localparam int WPE     = 3;
    localparam int DEPTH   = 16;
    localparam int AFULL   = 14;
    localparam int ENTRY_W = WORD_W * WPE;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int IDX_W   = $clog2(WPE) + 1;

    logic               clk;
    logic               rst;
    logic               flush;
    logic               wr_valid;
    logic               wr_ready;
    logic [WORD_W-1:0]  wr_data;
    logic [IDX_W-1:0]   wr_idx;
    logic               rd_valid;
    logic               rd_ready;
    logic [ENTRY_W-1:0] rd_data;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               afull;
    logic               ovf_err;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state.
    logic [ENTRY_W-1:0] mq[$];
    logic [WORD_W-1:0]  mpart[$];
    logic               movf;
    int                 mcommits;

    dma_desc_fifo #(
        .WORD_W          (WORD_W),
        .WORDS_PER_ENTRY (WPE),
        .DEPTH           (DEPTH),
        .AFULL_THRESH    (AFULL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .wr_valid_i (wr_valid),
        .wr_ready_o (wr_ready),
        .wr_data_i  (wr_data),
        .wr_idx_o   (wr_idx),
        .rd_valid_o (rd_valid),
        .rd_ready_i (rd_ready),
        .rd_data_o  (rd_data),
        .count_o    (count),
        .full_o     (full),
        .empty_o    (empty),
        .afull_o    (afull),
        .ovf_err_o  (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        mpart.delete();
        movf = 1'b0;
    endtask

    // Behavioural FIFO: a queue of whole entries plus a list of pending words.
    task automatic model_step(input logic wv, input logic [WORD_W-1:0] wd,
                              input logic rr, input logic fl);
        logic [ENTRY_W-1:0] e;
        bit                 was_full;
        was_full = (mq.size() == DEPTH);
        if (fl) begin
            model_reset();
        end else begin
            if (wv && was_full) movf = 1'b1;
            if (rr && mq.size() != 0) void'(mq.pop_front());
            if (wv && !was_full) begin
                mpart.push_back(wd);
                if (mpart.size() == WPE) begin
                    for (int k = 0; k < WPE; k++) e[k*WORD_W +: WORD_W] = mpart[k];
                    mq.push_back(e);
                    mpart.delete();
                    mcommits++;
                end
            end
        end
    endtask

    function automatic logic [ENTRY_W-1:0] model_head();
        return (mq.size() != 0) ? mq[0] : '0;
    endfunction

    // Drive one cycle of inputs, advance the model, clock one edge, settle.
    task automatic applyStimulus(input logic wv, input logic [WORD_W-1:0] wd,
                                 input logic rr, input logic fl);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        model_step(wv, wd, rr, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (count !== '0 || wr_idx !== '0 || ovf_err !== 1'b0 || wr_ready !== 1'b1 ||
            rd_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || afull !== 1'b0 ||
            rd_data !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_values: got cnt=%0d idx=%0d ovf=%b rdy=%b vld=%b emp=%b full=%b af=%b data=%0h, expected 0,0,0,1,0,1,0,0,0",
                     count, wr_idx, ovf_err, wr_ready, rd_valid, empty, full, afull, rd_data);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_entry();
        dma_desc_t exp_d;
        logic [IDX_W-1:0] exp_idx [3];
        exp_idx[0] = 1; exp_idx[1] = 2; exp_idx[2] = 0;
        exp_d[0] = 32'hA0; exp_d[1] = 32'hA1; exp_d[2] = 32'hA2;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, WORD_W'(32'hA0 + i), 1'b0, 1'b0);
            tests_run++;
            if (wr_idx !== exp_idx[i]) begin
                tests_failed++;
                $display("[TB] FAIL single_idx%0d: got %0d expected %0d", i, wr_idx, exp_idx[i]);
            end
        end
        idle_inputs();
        tests_run++;
        if (count !== CNT_W'(1) || rd_valid !== 1'b1 || rd_data !== ENTRY_W'(exp_d)) begin
            tests_failed++;
            $display("[TB] FAIL single_entry: got cnt=%0d vld=%b data=%0h expected 1,1,%0h",
                     count, rd_valid, rd_data, exp_d);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idle_inputs();
        tests_run++;
        if (count !== '0 || empty !== 1'b1 || rd_data !== '0) begin
            tests_failed++;
            $display("[TB] FAIL single_pop: got cnt=%0d emp=%b data=%0h expected 0,1,0", count, empty, rd_data);
        end
    endtask

    task automatic test_fill();
        for (int e = 0; e < DEPTH; e++) begin
            for (int w = 0; w < WPE; w++) applyStimulus(1'b1, WORD_W'($urandom), 1'b0, 1'b0);
            idle_inputs();
            tests_run++;
            if (count !== CNT_W'(e + 1) || afull !== ((e + 1) >= AFULL) ||
                rd_data !== model_head()) begin
                tests_failed++;
                $display("[TB] FAIL fill_%0d: got cnt=%0d af=%b head=%0h expected %0d,%b,%0h",
                         e, count, afull, rd_data, e + 1, (e + 1) >= AFULL, model_head());
            end
        end
        tests_run++;
        if (full !== 1'b1 || wr_ready !== 1'b0 || ovf_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL fill_full: got full=%b rdy=%b ovf=%b expected 1,0,0", full, wr_ready, ovf_err);
        end
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        idle_inputs();
        tests_run++;
        if (ovf_err !== 1'b1 || count !== CNT_W'(DEPTH) || wr_idx !== '0) begin
            tests_failed++;
            $display("[TB] FAIL fill_ovf: got ovf=%b cnt=%0d idx=%0d expected 1,%0d,0", ovf_err, count, wr_idx, DEPTH);
        end
    endtask

    task automatic test_stream();
        int  start_commits;
        int  cycles;
        int  bad;
        logic rr;
        start_commits = mcommits;
        cycles = 0;
        bad = 0;
        while ((mcommits - start_commits) < 40 && cycles < 400) begin
            rr = (mpart.size() == WPE - 1) || (mq.size() == DEPTH);
            applyStimulus(1'b1, WORD_W'($urandom), rr, 1'b0);
            cycles++;
            tests_run++;
            if (count !== CNT_W'(mq.size()) || rd_data !== model_head() ||
                count < CNT_W'(DEPTH - 1) || wr_idx !== IDX_W'(mpart.size())) begin
                tests_failed++;
                bad++;
                if (bad < 5)
                    $display("[TB] FAIL stream_cycle%0d: got cnt=%0d idx=%0d head=%0h expected %0d,%0d,%0h",
                             cycles, count, wr_idx, rd_data, mq.size(), mpart.size(), model_head());
            end
        end
        idle_inputs();
        tests_run++;
        if ((mcommits - start_commits) < 40) begin
            tests_failed++;
            $display("[TB] FAIL stream_budget: got %0d commits expected 40", mcommits - start_commits);
        end
        tests_run++;
        if (ovf_err !== movf) begin
            tests_failed++;
            $display("[TB] FAIL stream_ovf: got %b expected %b", ovf_err, movf);
        end
    endtask

    task automatic test_flush();
        dma_desc_t exp_d;
        int guard;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        guard = 0;
        while (mpart.size() != 2 && guard < 10) begin
            applyStimulus(1'b1, WORD_W'($urandom), 1'b0, 1'b0);
            guard++;
        end
        idle_inputs();
        tests_run++;
        if (wr_idx !== IDX_W'(2) || ovf_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL flush_setup: got idx=%0d ovf=%b expected 2,1", wr_idx, ovf_err);
        end
        applyStimulus(1'b1, 32'h5555_5555, 1'b1, 1'b1);
        idle_inputs();
        tests_run++;
        if (wr_idx !== '0 || count !== '0 || empty !== 1'b1 || ovf_err !== 1'b0 || rd_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_clear: got idx=%0d cnt=%0d emp=%b ovf=%b vld=%b expected 0,0,1,0,0",
                     wr_idx, count, empty, ovf_err, rd_valid);
        end
        exp_d[0] = 32'hB0; exp_d[1] = 32'hB1; exp_d[2] = 32'hB2;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, WORD_W'(32'hB0 + i), 1'b0, 1'b0);
        idle_inputs();
        tests_run++;
        if (count !== CNT_W'(1) || rd_data !== ENTRY_W'(exp_d)) begin
            tests_failed++;
            $display("[TB] FAIL flush_clean_entry: got cnt=%0d data=%0h expected 1,%0h", count, rd_data, exp_d);
        end
    endtask

    task automatic test_commit_pop();
        dma_desc_t exp_d;
        exp_d[0] = 32'hC0; exp_d[1] = 32'hC1; exp_d[2] = 32'hC2;
        applyStimulus(1'b1, 32'hC0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hC1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hC2, 1'b1, 1'b0);
        idle_inputs();
        tests_run++;
        if (count !== CNT_W'(1) || rd_valid !== 1'b1 || rd_data !== ENTRY_W'(exp_d) || wr_idx !== '0) begin
            tests_failed++;
            $display("[TB] FAIL commit_pop: got cnt=%0d vld=%b idx=%0d data=%0h expected 1,1,0,%0h",
                     count, rd_valid, wr_idx, rd_data, exp_d);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5 * WPE + 1; i++) applyStimulus(1'b1, WORD_W'($urandom), 1'b0, 1'b0);
        idle_inputs();
        tests_run++;
        if (count !== CNT_W'(6) || wr_idx !== IDX_W'(1)) begin
            tests_failed++;
            $display("[TB] FAIL areset_setup: got cnt=%0d idx=%0d expected 6,1", count, wr_idx);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (count !== '0 || wr_idx !== '0 || ovf_err !== 1'b0 || wr_ready !== 1'b1 ||
            rd_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || afull !== 1'b0 || rd_data !== '0) begin
            tests_failed++;
            $display("[TB] FAIL areset_immediate: got cnt=%0d idx=%0d ovf=%b rdy=%b vld=%b emp=%b data=%0h expected all reset",
                     count, wr_idx, ovf_err, wr_ready, rd_valid, empty, rd_data);
        end
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int bad;
        logic wv, rr, fl;
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            wv = ($urandom_range(0, 9) < 7);
            rr = ($urandom_range(0, 9) < 4);
            fl = ($urandom_range(0, 49) == 0);
            applyStimulus(wv, WORD_W'($urandom), rr, fl);
            tests_run++;
            if (count !== CNT_W'(mq.size()) || wr_idx !== IDX_W'(mpart.size()) ||
                rd_valid !== (mq.size() != 0) || rd_data !== model_head() ||
                full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) ||
                afull !== (mq.size() >= AFULL) || ovf_err !== movf ||
                wr_ready !== ((mq.size() != DEPTH) && !flush)) begin
                tests_failed++;
                bad++;
                if (bad < 5)
                    $display("[TB] FAIL random_cycle%0d: got cnt=%0d idx=%0d ovf=%b head=%0h expected %0d,%0d,%b,%0h",
                             c, count, wr_idx, ovf_err, rd_data, mq.size(), mpart.size(), movf, model_head());
            end
        end
        idle_inputs();
    endtask

    initial begin
        mcommits = 0;
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_single_entry();
        test_fill();
        test_stream();
        test_flush();
        test_commit_pop();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
